decode_operand_stage: RTL and testbench



---
 rtl/rv32_pkg.sv | 50 +++++
 rtl/decode_operand_stage_imm_gen.sv | 42 ++++
 rtl/decode_operand_stage.sv | 192 +++++++++++++++++++
 tb/tb_decode_operand_stage.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/rv32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rv32_pkg
// Description : Shared RV32I decode constants: datapath defaults, base-ISA
//               opcodes, immediate formats and an opcode-to-format helper.
// Revision    : 1.0 - initial release
// ============================================================================
package rv32_pkg;

   localparam int XLEN_DEFAULT       = 32;
   localparam int REG_ADDR_W_DEFAULT = 5;

   // Base RV32I major opcodes
   localparam logic [6:0] OP       = 7'b0110011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] LOAD     = 7'b0000011;
   localparam logic [6:0] STORE    = 7'b0100011;
   localparam logic [6:0] BRANCH   = 7'b1100011;
   localparam logic [6:0] JAL      = 7'b1101111;
   localparam logic [6:0] JALR     = 7'b1100111;
   localparam logic [6:0] LUI      = 7'b0110111;
   localparam logic [6:0] AUIPC    = 7'b0010111;
   localparam logic [6:0] SYSTEM   = 7'b1110011;
   localparam logic [6:0] MISC_MEM = 7'b0001111;

   typedef enum logic [2:0] {
      IMM_NONE = 3'd0,
      IMM_I    = 3'd1,
      IMM_S    = 3'd2,
      IMM_B    = 3'd3,
      IMM_U    = 3'd4,
      IMM_J    = 3'd5
   } imm_fmt_e;

   // Immediate format implied by the major opcode; unknown opcodes carry none
   function automatic imm_fmt_e imm_fmt_of(input logic [6:0] opcode);
      imm_fmt_e fmt;
      case (opcode)
         OP_IMM, LOAD, JALR, SYSTEM, MISC_MEM: fmt = IMM_I;
         STORE:                                fmt = IMM_S;
         BRANCH:                               fmt = IMM_B;
         LUI, AUIPC:                           fmt = IMM_U;
         JAL:                                  fmt = IMM_J;
         default:                              fmt = IMM_NONE;
      endcase
      return fmt;
   endfunction

endpackage : rv32_pkg
`default_nettype wire

// File: rtl/decode_operand_stage_imm_gen.sv
`default_nettype none
// ============================================================================
// Module      : imm_gen
// Description : Combinational RV32I immediate generator. I/S/B/U/J formats
//               are sign-extended from instr[31]; R-type and unknown opcodes
//               produce zero.
// Revision    : 1.0 - initial release
// ============================================================================
module imm_gen
   import rv32_pkg::*;
#(
   parameter int XLEN = rv32_pkg::XLEN_DEFAULT
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   imm_fmt_e           w_fmt;
   logic signed [31:0] w_imm32;

   assign w_fmt = imm_fmt_of(instr[6:0]);

   // Reassemble the scattered immediate bits for the decoded format
   always_comb begin
      w_imm32 = '0;
      case (w_fmt)
         IMM_I:   w_imm32 = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   w_imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   w_imm32 = {{19{instr[31]}}, instr[31], instr[7],
                             instr[30:25], instr[11:8], 1'b0};
         IMM_U:   w_imm32 = {instr[31:12], 12'b0};
         IMM_J:   w_imm32 = {{11{instr[31]}}, instr[31], instr[19:12],
                             instr[20], instr[30:21], 1'b0};
         default: w_imm32 = '0;
      endcase
   end

   // Signed cast extends the sign when XLEN exceeds 32
   assign imm = XLEN'(w_imm32);

endmodule : imm_gen
`default_nettype wire

// File: rtl/decode_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : decode_operand_stage
// Description : RV32I decode / operand-fetch stage. Drives the register file
//               read addresses, applies WB-to-ID bypass, generates the
//               immediate, stalls on load-use hazards and registers the
//               result into the ID/EX register behind a valid/ready handshake.
//               Optional macro DECODE_ILLEGAL_EN adds the out_illegal output.
// Revision    : 1.0 - initial release
// ============================================================================
module decode_operand_stage
   import rv32_pkg::*;
#(
   parameter int XLEN       = rv32_pkg::XLEN_DEFAULT,
   parameter int REG_ADDR_W = rv32_pkg::REG_ADDR_W_DEFAULT
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [XLEN-1:0]       in_pc,
   input  logic [31:0]           in_instr,
   output logic [REG_ADDR_W-1:0] rs1_addr,
   output logic [REG_ADDR_W-1:0] rs2_addr,
   input  logic [XLEN-1:0]       rs1_data,
   input  logic [XLEN-1:0]       rs2_data,
   input  logic                  wb_en,
   input  logic [REG_ADDR_W-1:0] wb_addr,
   input  logic [XLEN-1:0]       wb_data,
   input  logic                  flush,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [XLEN-1:0]       out_pc,
   output logic [31:0]           out_instr,
   output logic [XLEN-1:0]       out_rs1_val,
   output logic [XLEN-1:0]       out_rs2_val,
   output logic [XLEN-1:0]       out_imm,
   output logic [REG_ADDR_W-1:0] out_rd,
   output logic                  out_rd_we,
   output logic                  out_is_load
`ifdef DECODE_ILLEGAL_EN
   ,
   output logic                  out_illegal
`endif
);

   // ---------------------------------------------------------------------
   // Decode
   // ---------------------------------------------------------------------
   logic [6:0]            w_opcode;
   logic [REG_ADDR_W-1:0] w_rd;
   logic                  w_rs1_used;
   logic                  w_rs2_used;
   logic                  w_writes_rd;
   logic                  w_is_load;
   logic                  w_known;
   logic                  w_illegal;
   logic                  w_rd_we;
   logic [XLEN-1:0]       w_imm;

   assign w_opcode = in_instr[6:0];
   assign rs1_addr = REG_ADDR_W'(in_instr[19:15]);
   assign rs2_addr = REG_ADDR_W'(in_instr[24:20]);
   assign w_rd     = REG_ADDR_W'(in_instr[11:7]);

   // Classify the opcode: which sources it reads and whether it writes rd
   always_comb begin
      w_rs1_used  = 1'b1;
      w_rs2_used  = 1'b0;
      w_writes_rd = 1'b0;
      w_is_load   = 1'b0;
      w_known     = 1'b1;
      case (w_opcode)
         OP:              begin w_rs2_used = 1'b1; w_writes_rd = 1'b1; end
         OP_IMM, JALR:    w_writes_rd = 1'b1;
         LOAD:            begin w_writes_rd = 1'b1; w_is_load = 1'b1; end
         STORE, BRANCH:   w_rs2_used = 1'b1;
         JAL, LUI, AUIPC: begin w_rs1_used = 1'b0; w_writes_rd = 1'b1; end
         // CSR accesses write rd; ECALL/EBREAK (funct3 == 0) do not
         SYSTEM:          w_writes_rd = (in_instr[14:12] != 3'b000);
         MISC_MEM:        w_writes_rd = 1'b0;
         default:         w_known = 1'b0;
      endcase
   end

   // Opcode compare covers all 7 bits, so non-32-bit encodings are unknown too
   assign w_illegal = !w_known || (in_instr[1:0] != 2'b11);
   assign w_rd_we   = w_writes_rd && (w_rd != '0) && !w_illegal;

   imm_gen #(
      .XLEN (XLEN)
   ) u_imm_gen (
      .instr (in_instr),
      .imm   (w_imm)
   );

   // ---------------------------------------------------------------------
   // Operand select with WB bypass (x0 always reads zero)
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] w_rs1_val;
   logic [XLEN-1:0] w_rs2_val;

   // Bypass the value being written back this cycle over the stale RF read
   always_comb begin
      if (rs1_addr == '0)                     w_rs1_val = '0;
      else if (wb_en && (wb_addr == rs1_addr)) w_rs1_val = wb_data;
      else                                     w_rs1_val = rs1_data;

      if (rs2_addr == '0)                     w_rs2_val = '0;
      else if (wb_en && (wb_addr == rs2_addr)) w_rs2_val = wb_data;
      else                                     w_rs2_val = rs2_data;
   end

   // ---------------------------------------------------------------------
   // Hazard and handshake
   // ---------------------------------------------------------------------
   logic r_valid;
   logic r_is_load;
   logic [REG_ADDR_W-1:0] r_rd;
   logic w_hazard;
   logic w_transfer;

   assign w_hazard = r_valid && r_is_load && (r_rd != '0) &&
                     ((w_rs1_used && (r_rd == rs1_addr)) ||
                      (w_rs2_used && (r_rd == rs2_addr)));

   // A flush always consumes (and discards) whatever is offered
   assign in_ready   = flush || (!w_hazard && (!r_valid || out_ready));
   assign w_transfer = in_valid && in_ready && !flush;

   // ---------------------------------------------------------------------
   // ID/EX register
   // ---------------------------------------------------------------------
   logic [XLEN-1:0] r_pc;
   logic [31:0]     r_instr;
   logic [XLEN-1:0] r_rs1_val;
   logic [XLEN-1:0] r_rs2_val;
   logic [XLEN-1:0] r_imm;
   logic            r_rd_we;
   logic            r_illegal;

   // Load on transfer, drain to a bubble when EX consumes, hold when stalled
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid   <= 1'b0;
         r_pc      <= '0;
         r_instr   <= '0;
         r_rs1_val <= '0;
         r_rs2_val <= '0;
         r_imm     <= '0;
         r_rd      <= '0;
         r_rd_we   <= 1'b0;
         r_is_load <= 1'b0;
         r_illegal <= 1'b0;
      end else if (flush) begin
         r_valid   <= 1'b0;
      end else if (w_transfer) begin
         r_valid   <= 1'b1;
         r_pc      <= in_pc;
         r_instr   <= in_instr;
         r_rs1_val <= w_rs1_val;
         r_rs2_val <= w_rs2_val;
         r_imm     <= w_imm;
         r_rd      <= w_rd;
         r_rd_we   <= w_rd_we;
         r_is_load <= w_is_load;
         r_illegal <= w_illegal;
      end else if (out_ready) begin
         r_valid   <= 1'b0;
      end
   end

   assign out_valid   = r_valid;
   assign out_pc      = r_pc;
   assign out_instr   = r_instr;
   assign out_rs1_val = r_rs1_val;
   assign out_rs2_val = r_rs2_val;
   assign out_imm     = r_imm;
   assign out_rd      = r_rd;
   assign out_rd_we   = r_rd_we;
   assign out_is_load = r_is_load;

`ifdef DECODE_ILLEGAL_EN
   assign out_illegal = r_illegal;
`else
   // Illegal flag only matters when the port exists
   logic w_unused_illegal;
   assign w_unused_illegal = r_illegal;
`endif

endmodule : decode_operand_stage
`default_nettype wire

// File: tb/tb_decode_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_decode_operand_stage
// Description : Directed self-checking bench for decode_operand_stage.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_decode_operand_stage;

   logic        clk;
   logic        rst_n;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_pc;
   logic [31:0] in_instr;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        wb_en;
   logic [4:0]  wb_addr;
   logic [31:0] wb_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic [31:0] out_rs1_val;
   logic [31:0] out_rs2_val;
   logic [31:0] out_imm;
   logic [4:0]  out_rd;
   logic        out_rd_we;
   logic        out_is_load;
`ifdef DECODE_ILLEGAL_EN
   logic        out_illegal;
`endif

   int checks = 0;
   int errors = 0;

   decode_operand_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_pc       (in_pc),
      .in_instr    (in_instr),
      .rs1_addr    (rs1_addr),
      .rs2_addr    (rs2_addr),
      .rs1_data    (rs1_data),
      .rs2_data    (rs2_data),
      .wb_en       (wb_en),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .flush       (flush),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_pc      (out_pc),
      .out_instr   (out_instr),
      .out_rs1_val (out_rs1_val),
      .out_rs2_val (out_rs2_val),
      .out_imm     (out_imm),
      .out_rd      (out_rd),
      .out_rd_we   (out_rd_we),
      .out_is_load (out_is_load)
`ifdef DECODE_ILLEGAL_EN
      ,
      .out_illegal (out_illegal)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Advance one clock; sample point is 1 time unit after the rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] hold_pc, hold_instr, hold_rs1, hold_imm;

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; in_pc = '0; in_instr = '0;
      rs1_data = '0; rs2_data = '0; wb_en = 1'b0; wb_addr = '0;
      wb_data = '0; flush = 1'b0; out_ready = 1'b1;
      #12;
      chk("reset_valid", 32'(out_valid), 32'd0);
      chk("reset_instr", out_instr, 32'h0);
      chk("reset_imm",   out_imm, 32'h0);
      @(negedge clk); rst_n = 1'b1;
      tick();

      // addi x5,x0,-1
      in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hFFF00293; rs1_data = 32'hDEAD;
      #1;
      chk("addi_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("addi_valid", 32'(out_valid), 32'd1);
      chk("addi_imm",   out_imm, 32'hFFFFFFFF);
      chk("addi_rd",    32'(out_rd), 32'd5);
      chk("addi_rd_we", 32'(out_rd_we), 32'd1);
      chk("addi_rs1",   out_rs1_val, 32'h0);
      chk("addi_pc",    out_pc, 32'h100);

      // addi x6,x3,5 with WB writing x3 in the same cycle
      in_pc = 32'h104; in_instr = 32'h00518313; rs1_data = 32'h11;
      wb_en = 1'b1; wb_addr = 5'd3; wb_data = 32'h22;
      #1;
      chk("bypass_rs1_addr", 32'(rs1_addr), 32'd3);
      tick();
      chk("bypass_rs1_val", out_rs1_val, 32'h22);
      chk("bypass_imm",     out_imm, 32'h5);

      // x0 source while WB targets x0
      in_instr = 32'hFFF00293; rs1_data = 32'h44; wb_addr = 5'd0; wb_data = 32'h33;
      tick();
      chk("x0_rs1_val", out_rs1_val, 32'h0);

      // RF data passes when WB targets another register; rs2 bypassed
      in_instr = 32'h00238433; rs1_data = 32'h700; rs2_data = 32'h55;
      wb_addr = 5'd2; wb_data = 32'h99;
      tick();
      chk("nobyp_rs1_val", out_rs1_val, 32'h700);
      chk("byp_rs2_val",   out_rs2_val, 32'h99);
      wb_en = 1'b0;

      // lw x7,0(x1) then dependent add x8,x7,x2 -> one bubble
      in_pc = 32'h200; in_instr = 32'h0000A383;
      tick();
      chk("lw_is_load", 32'(out_is_load), 32'd1);
      chk("lw_rd",      32'(out_rd), 32'd7);
      in_pc = 32'h204; in_instr = 32'h00238433; rs1_data = 32'h700; rs2_data = 32'h200;
      #1;
      chk("hazard_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("bubble_valid",    32'(out_valid), 32'd0);
      chk("bubble_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("add_valid", 32'(out_valid), 32'd1);
      chk("add_instr", out_instr, 32'h00238433);
      chk("add_rs2",   out_rs2_val, 32'h200);
      chk("add_rd_we", 32'(out_rd_we), 32'd1);

      // lw x7 again, then lui x10 whose rs1 field is 7: no hazard
      in_pc = 32'h208; in_instr = 32'h0000A383;
      tick();
      in_pc = 32'h20C; in_instr = 32'h00038537;
      #1;
      chk("lui_no_hazard", 32'(in_ready), 32'd1);
      tick();
      chk("lui_imm",   out_imm, 32'h00038000);
      chk("lui_rd",    32'(out_rd), 32'd10);

      // Stall: EX not ready for 3 cycles
      hold_pc = out_pc; hold_instr = out_instr; hold_rs1 = out_rs1_val; hold_imm = out_imm;
      out_ready = 1'b0; in_pc = 32'h210; in_instr = 32'h00518313;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", 32'(in_ready), 32'd0);
         tick();
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_pc",    out_pc, hold_pc);
         chk("stall_instr", out_instr, hold_instr);
         chk("stall_rs1",   out_rs1_val, hold_rs1);
         chk("stall_imm",   out_imm, hold_imm);
      end

      // Flush during stall: input consumed, ID/EX emptied
      flush = 1'b1;
      #1;
      chk("flush_in_ready", 32'(in_ready), 32'd1);
      tick();
      chk("flush_valid", 32'(out_valid), 32'd0);
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      chk("flush_dropped", 32'(out_valid), 32'd0);

      // Immediate formats
      in_valid = 1'b1;
      in_instr = 32'hFE20AE23; // sw x2,-4(x1)
      tick();
      chk("s_imm",   out_imm, 32'hFFFFFFFC);
      chk("s_rd_we", 32'(out_rd_we), 32'd0);
      in_instr = 32'hFE208CE3; // beq x1,x2,-8
      tick();
      chk("b_imm",   out_imm, 32'hFFFFFFF8);
      in_instr = 32'h001000EF; // jal x1,2048
      tick();
      chk("j_imm",   out_imm, 32'h00000800);
      chk("j_rd_we", 32'(out_rd_we), 32'd1);

      // Unknown opcode with rd=5 and nonzero I-field
      in_instr = 32'hFFF002FF;
      tick();
      chk("unk_imm",   out_imm, 32'h0);
      chk("unk_rd_we", 32'(out_rd_we), 32'd0);
`ifdef DECODE_ILLEGAL_EN
      chk("unk_illegal", 32'(out_illegal), 32'd1);
      in_instr = 32'h0000007F;
      tick();
      chk("ill7f_illegal", 32'(out_illegal), 32'd1);
      chk("ill7f_rd_we",   32'(out_rd_we), 32'd0);
      in_instr = 32'hFFF00293;
      tick();
      chk("legal_illegal", 32'(out_illegal), 32'd0);
`endif

      // Asynchronous reset while holding a valid entry
      in_instr = 32'hFFF00293;
      tick();
      chk("pre_rst_valid", 32'(out_valid), 32'd1);
      in_valid = 1'b0;
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_valid", 32'(out_valid), 32'd0);
      chk("async_rst_rd",    32'(out_rd), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_decode_operand_stage
`default_nettype wire
